seq_scan_ctrl: RTL and testbench

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 111 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serializes words MSB first and counts occurrences of a configurable bit pattern.
module seq_scan_ctrl #(
    parameter int WORD_W  = 16,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               thresh_hit
);
    localparam int LW = $clog2(PAT_MAX + 1);
    localparam int BW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t             state, state_n;
    logic [PAT_MAX-1:0] pat, hist, hist_n, mask;
    logic [PAT_MAX:0]   one_sh;
    logic [LW-1:0]      len, len_cfg, bits_seen, bits_n;
    logic               overlap, stop_seen, handshake, last_bit, match, hit_n;
    logic [CNT_W-1:0]   thresh, cnt_n;
    logic [WORD_W-1:0]  word;
    logic [BW-1:0]      bit_cnt;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = state != IDLE;
        unique case (state)
            IDLE:  if (start) state_n = ARMED;
            ARMED: begin
                in_ready = 1'b1;
                if (in_valid)  state_n = SHIFT;
                else if (stop) state_n = IDLE;
            end
            SHIFT: if (last_bit) state_n = (stop_seen | stop) ? IDLE : ARMED;
            default: state_n = IDLE;
        endcase
    end

    assign handshake = in_ready & in_valid;
    assign last_bit  = bit_cnt == BW'(WORD_W - 1);
    assign len_cfg   = (cfg_len == 4'd0) ? LW'(1) : (32'(cfg_len) > PAT_MAX) ? LW'(PAT_MAX) : LW'(cfg_len);
    assign hist_n    = PAT_MAX'({hist, word[WORD_W-1]});
    assign bits_n    = (bits_seen == LW'(PAT_MAX)) ? bits_seen : bits_seen + 1'b1;
    // one_sh is one bit wider so a full-width pattern still yields an all-ones mask
    assign one_sh    = (PAT_MAX + 1)'(1) << len;
    assign mask      = PAT_MAX'(one_sh - 1'b1);
    assign match     = (state == SHIFT) && (((hist_n ^ pat) & mask) == '0) && (bits_n >= len);
    assign cnt_n     = clr ? '0 : (match && match_count != '1) ? match_count + 1'b1 : match_count;
    assign hit_n     = !clr && (thresh_hit || (thresh != '0 && cnt_n >= thresh));

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pat         <= '0;
            len         <= '0;
            overlap     <= 1'b0;
            thresh      <= '0;
            hist        <= '0;
            bits_seen   <= '0;
            word        <= '0;
            bit_cnt     <= '0;
            stop_seen   <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            thresh_hit  <= 1'b0;
        end else begin
            match_pulse <= match;
            match_count <= cnt_n;
            thresh_hit  <= hit_n;
            if (state == IDLE && start) begin
                pat         <= cfg_pattern;
                len         <= len_cfg;
                overlap     <= cfg_overlap;
                thresh      <= cfg_thresh;
                hist        <= '0;
                bits_seen   <= '0;
                match_count <= '0;
                thresh_hit  <= 1'b0;
            end
            if (handshake) begin
                word      <= in_data;
                bit_cnt   <= '0;
                stop_seen <= stop;
            end
            if (state == SHIFT) begin
                word      <= word << 1;
                bit_cnt   <= bit_cnt + 1'b1;
                stop_seen <= stop_seen | stop;
                hist      <= hist_n;
                bits_seen <= (match && !overlap) ? '0 : bits_n;
            end
        end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: scoreboard bench; expected pulses are queued at stimulus time and matched by a monitor.
module tb_seq_scan_ctrl;
    logic        clk = 0, reset = 1, start = 0, stop = 0, clr = 0, in_valid = 0, cfg_overlap = 0;
    logic [7:0]  cfg_pattern = 0, cfg_thresh = 0;
    logic [3:0]  cfg_len = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, busy, match_pulse, thresh_hit;
    logic [7:0]  match_count;
    logic        in_ready2, busy2, match_pulse2, thresh_hit2;
    logic [1:0]  match_count2;
    int          cyc = 0, checks = 0, errors = 0, e_cyc = 0;

    typedef struct {int cyc; int cnt; logic th;} exp_t;
    exp_t sb[$];
    exp_t got;

    seq_scan_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .match_pulse(match_pulse), .match_count(match_count), .thresh_hit(thresh_hit)
    );

    seq_scan_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh[1:0]), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .busy(busy2),
        .match_pulse(match_pulse2), .match_count(match_count2), .thresh_hit(thresh_hit2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int n, input logic th);
        exp_t x;
        x.cyc = c;
        x.cnt = n;
        x.th  = th;
        sb.push_back(x);
    endtask

    always @(negedge clk)
        if (!reset && match_pulse) begin
            if (sb.size() == 0) chk("unexpected_pulse_cycle", cyc, -1);
            else begin
                got = sb.pop_front();
                chk("pulse_cycle", cyc, got.cyc);
                chk("pulse_count", int'(match_count), got.cnt);
                chk("pulse_thresh", int'(thresh_hit), int'(got.th));
            end
        end

    // Config inputs are scrambled right after start; the latched copy must be unaffected.
    task automatic do_start(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] th);
        @(negedge clk);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_thresh  = th;
        start       = 1;
        @(negedge clk);
        start       = 0;
        cfg_pattern = 8'hFF;
        cfg_len     = 4'd1;
        cfg_overlap = ~ov;
        cfg_thresh  = 8'd1;
    endtask

    task automatic send_word(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        e_cyc    = cyc + 1;
        in_valid = 1;
        in_data  = d;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1;
        @(negedge clk) stop = 0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_match_pulse", int'(match_pulse), 0);
        chk("rst_match_count", int'(match_count), 0);
        chk("rst_thresh_hit", int'(thresh_hit), 0);
        reset = 0;

        // overlapping 1010 over 0xAAAA, with an ignored start mid-word
        do_start(8'h0A, 4'd4, 1, 8'd0);
        send_word(16'hAAAA);
        for (int i = 0; i < 7; i++) push(e_cyc + 4 + 2 * i, i + 1, 0);
        @(negedge clk);
        cfg_overlap = 0;
        cfg_pattern = 8'h00;
        start       = 1;
        @(negedge clk) start = 0;
        pulse_stop();
        wait_cyc(e_cyc + 17);
        chk("ovl_busy_after_stop", int'(busy), 0);
        chk("ovl_count", int'(match_count), 7);
        chk("sat_count", int'(match_count2), 3);
        chk("ovl_sb_empty", sb.size(), 0);

        // non-overlapping
        do_start(8'h0A, 4'd4, 0, 8'd0);
        chk("start_clears_count", int'(match_count), 0);
        send_word(16'hAAAA);
        for (int i = 0; i < 4; i++) push(e_cyc + 4 + 4 * i, i + 1, 0);
        pulse_stop();
        wait_cyc(e_cyc + 17);
        chk("novl_count", int'(match_count), 4);
        chk("novl_sb_empty", sb.size(), 0);

        // match spanning a word boundary
        do_start(8'h0A, 4'd4, 1, 8'd0);
        send_word(16'h0005);
        send_word(16'h0000);
        push(e_cyc + 1, 1, 0);
        pulse_stop();
        wait_cyc(e_cyc + 17);
        chk("span_count", int'(match_count), 1);
        chk("span_busy", int'(busy), 0);
        chk("span_sb_empty", sb.size(), 0);

        // threshold then clr
        do_start(8'h0A, 4'd4, 1, 8'd3);
        send_word(16'hAAAA);
        for (int i = 0; i < 7; i++) push(e_cyc + 4 + 2 * i, i + 1, (i + 1) >= 3);
        pulse_stop();
        wait_cyc(e_cyc + 17);
        chk("thr_sticky", int'(thresh_hit), 1);
        @(negedge clk) clr = 1;
        @(negedge clk) clr = 0;
        chk("clr_count", int'(match_count), 0);
        chk("clr_thresh", int'(thresh_hit), 0);
        chk("thr_sb_empty", sb.size(), 0);

        // len 12 clamps to 8
        do_start(8'hAA, 4'd12, 1, 8'd0);
        send_word(16'hAAAA);
        for (int i = 0; i < 5; i++) push(e_cyc + 8 + 2 * i, i + 1, 0);
        pulse_stop();
        wait_cyc(e_cyc + 17);
        chk("clamp_count", int'(match_count), 5);
        chk("clamp_sb_empty", sb.size(), 0);

        // reset mid-word
        do_start(8'h0A, 4'd4, 1, 8'd0);
        send_word(16'hAAAA);
        push(e_cyc + 4, 1, 0);
        push(e_cyc + 6, 2, 0);
        wait_cyc(e_cyc + 7);
        #1 reset = 1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pulse", int'(match_pulse), 0);
        chk("mid_rst_count", int'(match_count), 0);
        chk("mid_rst_thresh", int'(thresh_hit), 0);
        @(negedge clk) reset = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("rst_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
